// File: rtl/ay_seq_pkg.sv
// Shared types and constants for the AY bus sequencer and its arbiter.
package ay_seq_pkg;

   localparam int REG_W  = 4;
   localparam int DATA_W = 8;

   localparam logic AY_PORT_ADDR = 1'b1;
   localparam logic AY_PORT_DATA = 1'b0;

   // Grant index doubles as the bit position in the arbiter request vector
   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_PLY = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_RDATA,
      ST_DONE
   } ay_state_e;

endpackage

// File: rtl/ay_rr_arbiter.sv
// Two-way round-robin arbiter; on a tie the requester that was not granted last wins.
module ay_rr_arbiter
   import ay_seq_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       enable,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   always_comb begin
      gnt_valid = enable && (req != 2'b00);
      gnt_idx   = GNT_CPU;
      unique case (req)
         2'b01:   gnt_idx = GNT_CPU;
         2'b10:   gnt_idx = GNT_PLY;
         2'b11:   gnt_idx = ~last_grant;
         default: gnt_idx = GNT_CPU;
      endcase
   end

endmodule

// File: rtl/ay_bus_sequencer.sv
// Shares the AY glue port between CPU accesses and player writes; each access is an
// address-latch phase followed by a data phase, timed in ce-qualified clocks.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no access; arbitrate requests every clock
// ADDR     | register-select write of the latched register number
// WDATA    | data-port write of the latched write data
// RDATA    | data-port read; ay_q captured on the phase-ending clock
// DONE     | strobes off, one-clock ack to the grantee
module ay_bus_sequencer
   import ay_seq_pkg::*;
#(
   parameter int unsigned HOLD_CE = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ce,
   input  logic              cpu_req,
   input  logic              cpu_rd,
   input  logic [REG_W-1:0]  cpu_reg,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ply_req,
   input  logic [REG_W-1:0]  ply_reg,
   input  logic [DATA_W-1:0] ply_wdata,
   output logic              ply_ack,
   output logic              ay_address,
   output logic [DATA_W-1:0] ay_data,
   output logic              ay_wren,
   output logic              ay_rden,
   input  logic [DATA_W-1:0] ay_q,
   output logic              busy
);

   localparam logic [3:0] CNT_LAST = 4'(HOLD_CE - 1);

   ay_state_e         state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              rd_q, rd_d;
   logic [REG_W-1:0]  reg_q, reg_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              gnt_q, gnt_d;
   logic              last_grant_q, last_grant_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

   logic gnt_valid;
   logic gnt_idx;
   logic phase_end;

   ay_rr_arbiter u_arb (
      .req        ({ply_req, cpu_req}),
      .last_grant (last_grant_q),
      .enable     (state_q == ST_IDLE),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx)
   );

   assign phase_end = ce && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         rd_q         <= 1'b0;
         reg_q        <= '0;
         wdata_q      <= '0;
         gnt_q        <= GNT_CPU;
         last_grant_q <= GNT_PLY;
         cpu_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rd_q         <= rd_d;
         reg_q        <= reg_d;
         wdata_q      <= wdata_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         cpu_rdata_q  <= cpu_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rd_d         = rd_q;
      reg_d        = reg_q;
      wdata_d      = wdata_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      cpu_rdata_d  = cpu_rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               state_d      = ST_ADDR;
               cnt_d        = '0;
               gnt_d        = gnt_idx;
               last_grant_d = gnt_idx;
               if (gnt_idx == GNT_CPU) begin
                  rd_d    = cpu_rd;
                  reg_d   = cpu_reg;
                  wdata_d = cpu_wdata;
               end else begin
                  rd_d    = 1'b0;
                  reg_d   = ply_reg;
                  wdata_d = ply_wdata;
               end
            end
         end
         ST_ADDR, ST_WDATA, ST_RDATA: begin
            if (phase_end) begin
               cnt_d = '0;
               if (state_q == ST_ADDR) begin
                  state_d = rd_q ? ST_RDATA : ST_WDATA;
               end else begin
                  state_d = ST_DONE;
               end
               if (state_q == ST_RDATA) begin
                  cpu_rdata_d = ay_q;
               end
            end else if (ce) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus outputs depend only on registered state so they never glitch with requests
   always_comb begin
      ay_address = AY_PORT_DATA;
      ay_data    = '0;
      ay_wren    = 1'b0;
      ay_rden    = 1'b0;
      unique case (state_q)
         ST_ADDR: begin
            ay_address = AY_PORT_ADDR;
            ay_data    = {{(DATA_W-REG_W){1'b0}}, reg_q};
            ay_wren    = 1'b1;
         end
         ST_WDATA: begin
            ay_data = wdata_q;
            ay_wren = 1'b1;
         end
         ST_RDATA: ay_rden = 1'b1;
         default: ;
      endcase
   end

   assign cpu_ack   = (state_q == ST_DONE) && (gnt_q == GNT_CPU);
   assign ply_ack   = (state_q == ST_DONE) && (gnt_q == GNT_PLY);
   assign cpu_rdata = cpu_rdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ay_bus_sequencer.sv
// Directed bench for ay_bus_sequencer: HOLD_CE=1 instance plus a HOLD_CE=2 instance for ce stretching.
module tb_ay_bus_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ce = 1'b1;
   logic       ce2 = 1'b1;
   logic       cpu_req = 1'b0;
   logic       cpu_rd = 1'b0;
   logic [3:0] cpu_reg = '0;
   logic [7:0] cpu_wdata = '0;
   logic       ply_req = 1'b0;
   logic [3:0] ply_reg = '0;
   logic [7:0] ply_wdata = '0;
   logic [7:0] ay_q = '0;

   logic       cpu_ack, ply_ack, ay_address, ay_wren, ay_rden, busy;
   logic [7:0] cpu_rdata, ay_data;
   logic       cpu_ack2, ply_ack2, ay_address2, ay_wren2, ay_rden2, busy2;
   logic [7:0] cpu_rdata2, ay_data2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ay_bus_sequencer #(.HOLD_CE(1)) dut (
      .clk(clk), .reset_n(reset_n), .ce(ce),
      .cpu_req(cpu_req), .cpu_rd(cpu_rd), .cpu_reg(cpu_reg), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ply_req(ply_req), .ply_reg(ply_reg), .ply_wdata(ply_wdata), .ply_ack(ply_ack),
      .ay_address(ay_address), .ay_data(ay_data), .ay_wren(ay_wren), .ay_rden(ay_rden),
      .ay_q(ay_q), .busy(busy)
   );

   ay_bus_sequencer #(.HOLD_CE(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .ce(ce2),
      .cpu_req(cpu_req), .cpu_rd(cpu_rd), .cpu_reg(cpu_reg), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack2), .cpu_rdata(cpu_rdata2),
      .ply_req(ply_req), .ply_reg(ply_reg), .ply_wdata(ply_wdata), .ply_ack(ply_ack2),
      .ay_address(ay_address2), .ay_data(ay_data2), .ay_wren(ay_wren2), .ay_rden(ay_rden2),
      .ay_q(ay_q), .busy(busy2)
   );

   // Leaves the bench at a falling edge with reset released and all requests low.
   task automatic do_reset();
      reset_n = 1'b0;
      ce = 1'b1; ce2 = 1'b1;
      cpu_req = 1'b0; cpu_rd = 1'b0; cpu_reg = '0; cpu_wdata = '0;
      ply_req = 1'b0; ply_reg = '0; ply_wdata = '0; ay_q = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [13:0] obs;
      reset_n = 1'b0;
      @(negedge clk);
      obs = {ay_address, ay_data, ay_wren, ay_rden, cpu_ack, ply_ack, busy};
      checks++;
      if (obs !== 14'h0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=%h", obs, 14'h0);
      end
      checks++;
      if (cpu_rdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_rdata got=%h exp=00", cpu_rdata);
      end
      obs = {ay_address2, ay_data2, ay_wren2, ay_rden2, cpu_ack2, ply_ack2, busy2};
      checks++;
      if (obs !== 14'h0) begin
         errors++;
         $display("FAIL reset_outputs2 got=%h exp=%h", obs, 14'h0);
      end
   endtask

   task automatic test_cpu_write();
      logic [12:0] obs, exp;
      do_reset();
      cpu_req = 1'b1; cpu_rd = 1'b0; cpu_reg = 4'd7; cpu_wdata = 8'h38;
      for (int t = 1; t <= 5; t++) begin
         @(negedge clk);
         // {address, data, wren, rden, cpu_ack, busy}
         case (t)
            1:       exp = {1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1};
            2:       exp = {1'b0, 8'h38, 1'b1, 1'b0, 1'b0, 1'b1};
            3:       exp = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
            default: exp = 13'h0;
         endcase
         obs = {ay_address, ay_data, ay_wren, ay_rden, cpu_ack, busy};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL cpu_write t=%0d got=%h exp=%h", t, obs, exp);
         end
         if (t == 3) cpu_req = 1'b0;
      end
   endtask

   task automatic test_cpu_read();
      logic [12:0] obs, exp;
      do_reset();
      cpu_req = 1'b1; cpu_rd = 1'b1; cpu_reg = 4'd14;
      for (int t = 1; t <= 5; t++) begin
         @(negedge clk);
         case (t)
            1:       exp = {1'b1, 8'h0E, 1'b1, 1'b0, 1'b0, 1'b1};
            2:       exp = {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
            3:       exp = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
            default: exp = 13'h0;
         endcase
         obs = {ay_address, ay_data, ay_wren, ay_rden, cpu_ack, busy};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL cpu_read t=%0d got=%h exp=%h", t, obs, exp);
         end
         checks++;
         if (cpu_rdata !== ((t >= 3) ? 8'hA5 : 8'h00)) begin
            errors++;
            $display("FAIL cpu_rdata t=%0d got=%h exp=%h", t, cpu_rdata, (t >= 3) ? 8'hA5 : 8'h00);
         end
         if (t == 1) ay_q = 8'hA5;
         if (t == 3) begin
            cpu_req = 1'b0;
            ay_q = 8'h3C;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [14:0] obs, exp;
      logic        is_cpu;
      int          ph;
      do_reset();
      cpu_req = 1'b1; cpu_rd = 1'b0; cpu_reg = 4'd1; cpu_wdata = 8'h11;
      ply_req = 1'b1; ply_reg = 4'd2; ply_wdata = 8'h22;
      for (int t = 1; t <= 16; t++) begin
         @(negedge clk);
         ph = (t - 1) % 4;
         is_cpu = (((t - 1) / 4) % 2) == 0;
         // {address, data, wren, rden, cpu_ack, ply_ack, busy}
         case (ph)
            0:       exp = {1'b1, is_cpu ? 8'h01 : 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            1:       exp = {1'b0, is_cpu ? 8'h11 : 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            2:       exp = {1'b0, 8'h00, 1'b0, 1'b0, is_cpu, ~is_cpu, 1'b1};
            default: exp = 15'h0;
         endcase
         obs = {ay_address, ay_data, ay_wren, ay_rden, cpu_ack, ply_ack, busy};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL back_to_back t=%0d got=%h exp=%h", t, obs, exp);
         end
      end
      cpu_req = 1'b0; ply_req = 1'b0;
   endtask

   task automatic test_ce_hold();
      logic [12:0] obs, exp;
      do_reset();
      ply_reg = 4'd9; ply_wdata = 8'h5C;
      for (int t = 0; t <= 14; t++) begin
         if (t > 0) begin
            // {address, data, wren, rden, ply_ack, busy}
            if (t <= 5)       exp = {1'b1, 8'h09, 1'b1, 1'b0, 1'b0, 1'b1};
            else if (t <= 11) exp = {1'b0, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b1};
            else if (t == 12) exp = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
            else              exp = 13'h0;
            obs = {ay_address2, ay_data2, ay_wren2, ay_rden2, ply_ack2, busy2};
            checks++;
            if (obs !== exp) begin
               errors++;
               $display("FAIL ce_hold t=%0d got=%h exp=%h", t, obs, exp);
            end
         end
         ce2 = ((t % 3) == 2);
         ply_req = (t < 13);
         @(negedge clk);
      end
   endtask

   task automatic test_reset_midflight();
      logic [14:0] obs;
      do_reset();
      ply_req = 1'b1; ply_reg = 4'd4; ply_wdata = 8'h44;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({ay_address, ay_data, ay_wren} !== {1'b0, 8'h44, 1'b1}) begin
         errors++;
         $display("FAIL midflight_wdata got=%h exp=%h", {ay_address, ay_data, ay_wren}, {1'b0, 8'h44, 1'b1});
      end
      #2 reset_n = 1'b0;
      #1;
      obs = {ay_address, ay_data, ay_wren, ay_rden, cpu_ack, ply_ack, busy};
      checks++;
      if (obs !== 15'h0) begin
         errors++;
         $display("FAIL async_reset got=%h exp=%h", obs, 15'h0);
      end
      @(negedge clk);
      checks++;
      if (ply_ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_ack got=%b exp=0", ply_ack);
      end
      cpu_req = 1'b1; cpu_rd = 1'b0; cpu_reg = 4'd3; cpu_wdata = 8'h77;
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({ay_address, ay_data, ay_wren} !== {1'b1, 8'h03, 1'b1}) begin
         errors++;
         $display("FAIL first_grant_cpu got=%h exp=%h", {ay_address, ay_data, ay_wren}, {1'b1, 8'h03, 1'b1});
      end
      @(negedge clk);
      checks++;
      if (ay_data !== 8'h77) begin
         errors++;
         $display("FAIL first_grant_data got=%h exp=77", ay_data);
      end
      @(negedge clk);
      checks++;
      if ({cpu_ack, ply_ack} !== 2'b10) begin
         errors++;
         $display("FAIL first_grant_ack got=%b exp=10", {cpu_ack, ply_ack});
      end
      cpu_req = 1'b0;
   endtask

   task automatic test_req_drop();
      int acks = 0;
      do_reset();
      cpu_req = 1'b1; cpu_rd = 1'b0; cpu_reg = 4'd5; cpu_wdata = 8'h9A;
      @(negedge clk);
      checks++;
      if ({ay_address, ay_data} !== {1'b1, 8'h05}) begin
         errors++;
         $display("FAIL drop_addr got=%h exp=%h", {ay_address, ay_data}, {1'b1, 8'h05});
      end
      if (cpu_ack) acks++;
      cpu_req = 1'b0; cpu_reg = 4'd0; cpu_wdata = 8'hFF;
      @(negedge clk);
      checks++;
      if ({ay_address, ay_data, ay_wren} !== {1'b0, 8'h9A, 1'b1}) begin
         errors++;
         $display("FAIL drop_wdata got=%h exp=%h", {ay_address, ay_data, ay_wren}, {1'b0, 8'h9A, 1'b1});
      end
      if (cpu_ack) acks++;
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b1) begin
         errors++;
         $display("FAIL drop_ack got=%b exp=1", cpu_ack);
      end
      if (cpu_ack) acks++;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         if (cpu_ack) acks++;
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle t=%0d got=%b exp=0", t, busy);
         end
      end
      checks++;
      if (acks != 1) begin
         errors++;
         $display("FAIL drop_ack_count got=%0d exp=1", acks);
      end
   endtask

   initial begin
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_back_to_back();
      test_ce_hold();
      test_reset_midflight();
      test_req_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
